// File: rtl/rc5_decipher_core_pkg.sv
// rc5_decipher_core_pkg: shared RC5 widths, S-table sizing, FSM encoding and magic constants.
//   rc5_t(r)  : S-table entry count 2r+2 for r rounds
//   rc5_pw(w) : magic constant P for word width w (16/32/64)
//   rc5_qw(w) : magic constant Q for word width w (16/32/64)
package rc5_decipher_core_pkg;
   localparam int RC5_W = 16;
   localparam int RC5_R = 12;
   typedef enum logic [1:0] {IDLE, ISSUE, APPLY, DONE} rc5_state_e;
   function automatic int rc5_t(input int r);
      return 2 * r + 2;
   endfunction
   function automatic logic [63:0] rc5_pw(input int w);
      return w == 16 ? 64'hB7E1 : w == 32 ? 64'hB7E1_5163 : 64'hB7E1_5162_8AED_2A6B;
   endfunction
   function automatic logic [63:0] rc5_qw(input int w);
      return w == 16 ? 64'h9E37 : w == 32 ? 64'h9E37_79B9 : 64'h9E37_79B9_7F4A_7C15;
   endfunction
endpackage

// File: rtl/rc5_rotr.sv
// rc5_rotr: combinational right-rotate of a W-bit word.
//   din  : word to rotate
//   amt  : rotate amount, log2(W) bits
//   dout : din rotated right by amt
module rc5_rotr #(
   parameter int W = 16
) (
   input  logic [W-1:0]         din,
   input  logic [$clog2(W)-1:0] amt,
   output logic [W-1:0]         dout
);
   // Shifting the doubled word lets the wrapped bits fall into the low half.
   assign dout = W'({din, din} >> amt);
endmodule

// File: rtl/rc5_decipher_core.sv
// rc5_decipher_core: iterative RC5 decryption, one S-table lookup per ISSUE/APPLY pair.
//   clk, rst             : clock, asynchronous active-low reset
//   iStart               : level start request, honoured only in IDLE
//   iA_cipher, iB_cipher : ciphertext words, latched on the start edge
//   oS_address, iS_data  : S-table port, data valid one cycle after the address
//   oA_decipher, oB_decipher : plaintext, held until the next completion
//   oBusy, oDone         : operation in progress / result ready
module rc5_decipher_core
   import rc5_decipher_core_pkg::*;
#(
   parameter int W        = RC5_W,
   parameter int R        = RC5_R,
   parameter int S_LENGTH = $clog2(rc5_t(R))
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iStart,
   input  logic [W-1:0]        iA_cipher,
   input  logic [W-1:0]        iB_cipher,
   output logic [S_LENGTH-1:0] oS_address,
   input  logic [W-1:0]        iS_data,
   output logic [W-1:0]        oA_decipher,
   output logic [W-1:0]        oB_decipher,
   output logic                oBusy,
   output logic                oDone
);
   localparam int LW = $clog2(W);
   localparam logic [S_LENGTH-1:0] K_TOP = S_LENGTH'(rc5_t(R) - 1);

   rc5_state_e          state_q, state_d;
   logic [W-1:0]        a_q, a_d, b_q, b_d, oa_q, oa_d, ob_q, ob_d;
   logic [S_LENGTH-1:0] k_q, k_d, addr_q, addr_d;
   logic                busy_q, busy_d, done_q, done_d;

   // Odd k updates B (rotated by A, mixed with A); even k updates A symmetrically.
   logic          path_b, k_hi;
   logic [W-1:0]  diff, rot, res;
   assign path_b = k_q[0];
   assign k_hi   = |k_q[S_LENGTH-1:1];
   assign diff   = (path_b ? b_q : a_q) - iS_data;

   rc5_rotr #(.W(W)) u_rotr (
      .din  (diff),
      .amt  (path_b ? a_q[LW-1:0] : b_q[LW-1:0]),
      .dout (rot)
   );

   // The last two indices are the plain pre-whitening subtractions.
   assign res = k_hi ? (rot ^ (path_b ? a_q : b_q)) : diff;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      addr_d  = addr_q;
      oa_d    = oa_q;
      ob_d    = ob_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         IDLE: if (iStart) begin
            a_d     = iA_cipher;
            b_d     = iB_cipher;
            k_d     = K_TOP;
            addr_d  = K_TOP;
            busy_d  = 1'b1;
            state_d = ISSUE;
         end
         // Address is already on the bus during ISSUE, so the data lands in APPLY.
         ISSUE: state_d = APPLY;
         APPLY: begin
            if (path_b) b_d = res;
            else        a_d = res;
            if (k_q != '0) begin
               k_d     = k_q - S_LENGTH'(1);
               addr_d  = k_q - S_LENGTH'(1);
               state_d = ISSUE;
            end else begin
               oa_d    = res;
               ob_d    = b_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: if (!iStart) begin
            done_d  = 1'b0;
            addr_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         k_q     <= '0;
         addr_q  <= '0;
         oa_q    <= '0;
         ob_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         oa_q    <= oa_d;
         ob_q    <= ob_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign oS_address  = addr_q;
   assign oA_decipher = oa_q;
   assign oB_decipher = ob_q;
   assign oBusy       = busy_q;
   assign oDone       = done_q;
endmodule
